// File: rtl/cmd_gate_pkg.sv
// -----------------------------------------------------------------------------
// cmd_gate_pkg
//   Shared types and helpers for the command-gated count-enable controller.
//   - cmd_class_e  : classification of one received command word
//   - gate_state_e : controller FSM state (also driven out on STATE)
//   - popcnt_width : width needed to hold a popcount of a w-bit word
// -----------------------------------------------------------------------------
package cmd_gate_pkg;

    // Classification of a command word by its number of set bits.
    typedef enum logic [1:0] {
        CLS_STOP    = 2'd0,
        CLS_START   = 2'd1,
        CLS_INVALID = 2'd2
    } cmd_class_e;

    // Controller state; the encoding is visible on the STATE output.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_DONE     = 2'd2
    } gate_state_e;

    // Width of the confirmation counter; large enough for CONFIRM_N up to 15.
    localparam int CONF_CNT_W = 4;

    // A popcount of a w-bit word ranges over 0..w, so it needs clog2(w+1) bits.
    function automatic int popcnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/cmd_classify.sv
// -----------------------------------------------------------------------------
// cmd_classify
//   Purely combinational classifier for one command word. Counts the set bits
//   and compares against the tolerance thresholds:
//     ones >= CMD_W-TOL -> CLS_START
//     ones <= TOL       -> CLS_STOP
//     otherwise         -> CLS_INVALID
//   Since 2*TOL < CMD_W the two ranges never overlap.
//
// Parameters: CMD_W (word width), TOL (bit errors tolerated)
// Ports:
//   command  in  CMD_W  word to classify
//   cls      out 2      resulting class
// -----------------------------------------------------------------------------
module cmd_classify
    import cmd_gate_pkg::*;
#(
    parameter int CMD_W = 16,
    parameter int TOL   = 4
) (
    input  logic [CMD_W-1:0] command,
    output cmd_class_e       cls
);

    localparam int PW = popcnt_width(CMD_W);

    // Thresholds held at the full popcount width so no compare is truncated.
    localparam logic [PW-1:0] START_TH = PW'(CMD_W - TOL);
    localparam logic [PW-1:0] STOP_TH  = PW'(TOL);

    logic [PW-1:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < CMD_W; i++) begin
            ones = ones + PW'(command[i]);
        end
    end

    always_comb begin
        cls = CLS_INVALID;
        if (ones >= START_TH) begin
            cls = CLS_START;
        end else if (ones <= STOP_TH) begin
            cls = CLS_STOP;
        end
    end

endmodule

// File: rtl/cmd_gate_controller.sv
// -----------------------------------------------------------------------------
// cmd_gate_controller
//   Count-enable controller driven by command words from an SPI receiver.
//   Each valid word is classified (START / STOP / INVALID) by popcount with a
//   bit-error tolerance, registered (stage 1), then confirmed against the
//   previously stored class (stage 2). Once CONFIRM_N consecutive agreeing
//   words arrive, the FSM acts on the same edge as the confirmation.
//   A nonzero GATE_LEN, latched on entry to COUNTING, makes the gate timed:
//   START_COUNT stays high for exactly GATE_LEN cycles and GATE_DONE pulses
//   as it falls.
//
// Optional feature (macro CMD_GATE_ERRCNT_EN): adds ERR_COUNT, a saturating
//   count of INVALID words cleared only by reset.
//
// Ports:
//   CLK          in   1         clock, rising edge
//   RST_N        in   1         asynchronous active-low reset
//   COMMAND      in   CMD_W     command word
//   CMD_VALID    in   1         one-cycle strobe per word
//   GATE_LEN     in   GATE_W    gate length in cycles, 0 = untimed
//   START_COUNT  out  1         photon counter enable
//   GATE_DONE    out  1         pulse when a timed gate expires
//   CMD_ERROR    out  1         pulse per INVALID word
//   STATE        out  2         FSM state (00 IDLE, 01 COUNTING, 10 DONE)
//   ERR_COUNT    out  ERRCNT_W  INVALID-word count (only with the macro)
// -----------------------------------------------------------------------------
module cmd_gate_controller
    import cmd_gate_pkg::*;
#(
    parameter int CMD_W     = 16,
    parameter int TOL       = 4,
    parameter int CONFIRM_N = 1,
    parameter int GATE_W    = 24
`ifdef CMD_GATE_ERRCNT_EN
    ,
    parameter int ERRCNT_W  = 8
`endif
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [CMD_W-1:0]  COMMAND,
    input  logic              CMD_VALID,
    input  logic [GATE_W-1:0] GATE_LEN,
    output logic              START_COUNT,
    output logic              GATE_DONE,
    output logic              CMD_ERROR,
    output logic [1:0]        STATE
`ifdef CMD_GATE_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] ERR_COUNT
`endif
);

    localparam logic [CONF_CNT_W-1:0] CONF_MAX = CONF_CNT_W'(CONFIRM_N);

    // ------------------------------------------------------------------
    // Stage 1: classify and register
    // ------------------------------------------------------------------
    cmd_class_e cls_comb;
    cmd_class_e cls_q, cls_d;
    logic       cls_vld_q, cls_vld_d;

    cmd_classify #(
        .CMD_W (CMD_W),
        .TOL   (TOL)
    ) u_classify (
        .command (COMMAND),
        .cls     (cls_comb)
    );

    always_comb begin
        cls_vld_d = CMD_VALID;
        cls_d     = CMD_VALID ? cls_comb : cls_q;
    end

    // ------------------------------------------------------------------
    // Stage 2: confirmation
    // ------------------------------------------------------------------
    logic [CONF_CNT_W-1:0] cnt_q, cnt_d;
    cmd_class_e            stored_cls_q, stored_cls_d;
    logic                  stored_vld_q, stored_vld_d;
    logic                  cmd_error_q, cmd_error_d;
    logic                  confirm_start;
    logic                  confirm_stop;

    gate_state_e           state_q, state_d;

    always_comb begin
        cnt_d         = cnt_q;
        stored_cls_d  = stored_cls_q;
        stored_vld_d  = stored_vld_q;
        cmd_error_d   = 1'b0;
        confirm_start = 1'b0;
        confirm_stop  = 1'b0;

        if (cls_vld_q) begin
            if (cls_q == CLS_INVALID) begin
                // An invalid word breaks any run in progress.
                cnt_d        = '0;
                stored_vld_d = 1'b0;
                cmd_error_d  = 1'b1;
            end else begin
                if (stored_vld_q && (stored_cls_q == cls_q)) begin
                    if (cnt_q != CONF_MAX) begin
                        cnt_d = cnt_q + CONF_CNT_W'(1);
                    end
                end else begin
                    cnt_d        = CONF_CNT_W'(1);
                    stored_cls_d = cls_q;
                    stored_vld_d = 1'b1;
                end
                // Once saturated, every further agreeing word is confirmed.
                if (cnt_d == CONF_MAX) begin
                    confirm_start = (cls_q == CLS_START);
                    confirm_stop  = (cls_q == CLS_STOP);
                end
            end
        end

        // A START confirmed while the FSM sits in DONE is discarded, and the
        // run that produced it must start over.
        if ((state_q == ST_DONE) && confirm_start) begin
            cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Gate FSM
    // ------------------------------------------------------------------
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic              start_count_q, start_count_d;
    logic              gate_done_q, gate_done_d;

    always_comb begin
        state_d       = state_q;
        start_count_d = start_count_q;
        gate_done_d   = 1'b0;
        gate_cnt_d    = gate_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (confirm_start) begin
                    state_d       = ST_COUNTING;
                    start_count_d = 1'b1;
                    gate_cnt_d    = GATE_LEN;
                end
            end
            ST_COUNTING: begin
                // STOP is checked first so it beats a simultaneous expiry.
                if (confirm_stop) begin
                    state_d       = ST_IDLE;
                    start_count_d = 1'b0;
                    gate_cnt_d    = '0;
                end else if (gate_cnt_q != '0) begin
                    // A latched length of 0 never enters this branch, which
                    // is what makes the gate untimed.
                    gate_cnt_d = gate_cnt_q - GATE_W'(1);
                    if (gate_cnt_q == GATE_W'(1)) begin
                        state_d       = ST_DONE;
                        start_count_d = 1'b0;
                        gate_done_d   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d       = ST_IDLE;
                start_count_d = 1'b0;
            end
            default: begin
                state_d       = ST_IDLE;
                start_count_d = 1'b0;
                gate_cnt_d    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cls_q         <= CLS_STOP;
            cls_vld_q     <= 1'b0;
            cnt_q         <= '0;
            stored_cls_q  <= CLS_STOP;
            stored_vld_q  <= 1'b0;
            cmd_error_q   <= 1'b0;
            state_q       <= ST_IDLE;
            start_count_q <= 1'b0;
            gate_done_q   <= 1'b0;
            gate_cnt_q    <= '0;
        end else begin
            cls_q         <= cls_d;
            cls_vld_q     <= cls_vld_d;
            cnt_q         <= cnt_d;
            stored_cls_q  <= stored_cls_d;
            stored_vld_q  <= stored_vld_d;
            cmd_error_q   <= cmd_error_d;
            state_q       <= state_d;
            start_count_q <= start_count_d;
            gate_done_q   <= gate_done_d;
            gate_cnt_q    <= gate_cnt_d;
        end
    end

    assign START_COUNT = start_count_q;
    assign GATE_DONE   = gate_done_q;
    assign CMD_ERROR   = cmd_error_q;
    assign STATE       = state_q;

    // ------------------------------------------------------------------
    // Optional saturating error counter
    // ------------------------------------------------------------------
`ifdef CMD_GATE_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    // Counts alongside the CMD_ERROR pulse it mirrors.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (cmd_error_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ERR_COUNT = err_cnt_q;
`endif

endmodule
